grid_cursor_input: RTL

GRID_CURSOR_INPUT -- requirements
Module: grid_cursor_input

---
 rtl/grid_cursor_input.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/grid_cursor_input.sv
// Purpose: debounced three-button cursor over a CELLS-entry occupancy grid that skips occupied cells.
// Latency: press -> event is 2 sync + DEB_CYCLES filter + 1 flop; then 1 cycle per FSM move/seek step.
// Backpressure: none; events arriving while seeking or full are dropped, never queued.
//
// Ports: CLOCK_50 clock; reset synchronous active-high;
//   BUTTON_NEXT / BUTTON_PREV / BUTTON_ENTER raw active-low buttons; grid_marked cell occupancy;
//   cell_cursor registered index; cell_enter one-cycle select pulse;
//   cursor_valid cursor rests on a free cell; grid_full every cell is marked.
// Optional feature: define GRID_CURSOR_AUTO_REPEAT_EN so held NEXT/PREV repeat every REPEAT_CYCLES.
module grid_cursor_input #(
  parameter int CELLS         = 9,
  parameter int CW            = 4,
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             BUTTON_NEXT,
  input  logic             BUTTON_PREV,
  input  logic             BUTTON_ENTER,
  input  logic [CELLS-1:0] grid_marked,
  output logic [CW-1:0]    cell_cursor,
  output logic             cell_enter,
  output logic             cursor_valid,
  output logic             grid_full
);

  localparam int DW      = $clog2(DEB_CYCLES + 1);
  localparam int B_NEXT  = 0;
  localparam int B_PREV  = 1;
  localparam int B_ENTER = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_FULL = 2'd2
  } state_t;

  // ---------------- button conditioning ----------------
  logic [2:0]    btn_raw;
  logic [2:0]    sync0;
  logic [2:0]    sync1;
  logic [2:0]    deb;
  logic [2:0]    press;
  logic [2:0]    rep;
  logic [2:0]    evt;
  logic [DW-1:0] deb_cnt [3];

  assign btn_raw = {BUTTON_ENTER, BUTTON_PREV, BUTTON_NEXT};

  // A press is the cycle in which the filter commits a 1->0 change.
  always_comb begin
    press = '0;
    for (int i = 0; i < 3; i++)
      press[i] = deb[i] & ~sync1[i] & (deb_cnt[i] == DW'(DEB_CYCLES - 1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync0   <= '1;
      sync1   <= '1;
      deb     <= '1;
      evt     <= '0;
      deb_cnt <= '{default: '0};
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
      for (int i = 0; i < 3; i++) begin
        // Count consecutive cycles of disagreement; any agreement restarts the count.
        if (sync1[i] != deb[i]) begin
          if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
            deb[i]     <= sync1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
      evt <= press | rep;
    end
  end

`ifdef GRID_CURSOR_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_cnt [2];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rep_cnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (deb[i])
          rep_cnt[i] <= '0;
        else if (rep_cnt[i] == RW'(REPEAT_CYCLES - 1))
          rep_cnt[i] <= '0;
        else
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rep = '0;
    for (int i = 0; i < 2; i++)
      rep[i] = ~deb[i] & (rep_cnt[i] == RW'(REPEAT_CYCLES - 1));
  end
`else
  assign rep = '0;
`endif

  // ---------------- cursor FSM ----------------
  state_t        state;
  state_t        state_d;
  logic          dir_fwd;
  logic          dir_fwd_d;
  logic [CW-1:0] cursor_d;
  logic [CW-1:0] cur_inc;
  logic [CW-1:0] cur_dec;
  logic          enter_d;
  logic          here_marked;
  logic          all_marked;
  logic          ev_next_only;
  logic          ev_prev_only;

  assign all_marked   = &grid_marked;
  assign here_marked  = |(grid_marked & (CELLS'(1) << cell_cursor));
  assign cur_inc      = (cell_cursor == CW'(CELLS - 1)) ? '0 : cell_cursor + 1'b1;
  assign cur_dec      = (cell_cursor == '0) ? CW'(CELLS - 1) : cell_cursor - 1'b1;
  // NEXT and PREV together cancel each other.
  assign ev_next_only = evt[B_NEXT] & ~evt[B_PREV];
  assign ev_prev_only = evt[B_PREV] & ~evt[B_NEXT];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= S_SEEK;
      dir_fwd      <= 1'b1;
      cell_cursor  <= '0;
      cell_enter   <= 1'b0;
      cursor_valid <= 1'b0;
      grid_full    <= 1'b0;
    end else begin
      state        <= state_d;
      dir_fwd      <= dir_fwd_d;
      cell_cursor  <= cursor_d;
      cell_enter   <= enter_d;
      cursor_valid <= (state == S_IDLE);
      grid_full    <= (state == S_FULL);
    end
  end

  always_comb begin
    state_d   = state;
    dir_fwd_d = dir_fwd;
    cursor_d  = cell_cursor;
    if (all_marked) begin
      state_d = S_FULL;
    end else begin
      case (state)
        S_IDLE: begin
          if (here_marked) begin
            state_d   = S_SEEK;
            dir_fwd_d = 1'b1;
          end else if (evt[B_ENTER]) begin
            state_d = S_IDLE;  // ENTER wins; any simultaneous move is dropped
          end else if (ev_next_only) begin
            cursor_d  = cur_inc;
            dir_fwd_d = 1'b1;
            state_d   = S_SEEK;
          end else if (ev_prev_only) begin
            cursor_d  = cur_dec;
            dir_fwd_d = 1'b0;
            state_d   = S_SEEK;
          end
        end
        S_SEEK: begin
          if (!here_marked)
            state_d = S_IDLE;
          else
            cursor_d = dir_fwd ? cur_inc : cur_dec;
        end
        S_FULL: begin
          state_d   = S_SEEK;
          dir_fwd_d = 1'b1;
        end
        default: begin
          state_d   = S_SEEK;
          dir_fwd_d = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    enter_d = (state == S_IDLE) & ~all_marked & ~here_marked & evt[B_ENTER];
  end

endmodule
